// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding and load-use hazard controller.
// Tracks in-flight destinations in EX/MEM/WB and drives the bypass muxes.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic              fwd_a_sel0,
  output logic              fwd_a_sel1,
  output logic              fwd_b_sel0,
  output logic              fwd_b_sel1,
  output logic              stall,
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } ex_ent_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } mem_ent_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
  } wb_ent_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ex_ent_t          ex_q, ex_d;
  mem_ent_t         mem_q, mem_d;
  wb_ent_t          wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       ld_in_ex;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       stall_raw;
  logic       mem_src;
  logic       wb_src;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // Youngest producer wins: MEM (EX/MEM result) over WB (MEM/WB result).
  function automatic logic [1:0] pick_src(
    input logic              ex_v,
    input logic              used,
    input logic [REG_AW-1:0] rs,
    input logic              m_ok,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_ok,
    input logic [REG_AW-1:0] w_rd
  );
    logic [1:0] s;
    s = 2'b00;
    if (ex_v && used) begin
      if (m_ok && (m_rd == rs))
        s = 2'b01;
      else if (w_ok && (w_rd == rs))
        s = 2'b10;
    end
    return s;
  endfunction

  always_comb begin
    ld_in_ex  = ex_q.v & ex_q.ld & ex_q.wr & (ex_q.rd != '0);
    rs1_hit   = id_rs1_used & (id_rs1 == ex_q.rd);
    rs2_hit   = id_rs2_used & (id_rs2 == ex_q.rd);
    stall_raw = id_valid & ld_in_ex & (rs1_hit | rs2_hit);
    stall     = stall_raw & ~flush & ~hold;
    ex_bubble = (stall | flush) & ~hold;
  end

  always_comb begin
    mem_src = mem_q.v & mem_q.wr & ~mem_q.ld & (mem_q.rd != '0);
    wb_src  = wb_q.v & wb_q.wr & (wb_q.rd != '0);
    sel_a   = pick_src(ex_q.v, ex_q.u1, ex_q.rs1,
                       mem_src, mem_q.rd, wb_src, wb_q.rd);
    sel_b   = pick_src(ex_q.v, ex_q.u2, ex_q.rs2,
                       mem_src, mem_q.rd, wb_src, wb_q.rd);
  end

  assign fwd_a_sel0 = sel_a[0];
  assign fwd_a_sel1 = sel_a[1];
  assign fwd_b_sel0 = sel_b[0];
  assign fwd_b_sel1 = sel_b[1];
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      wb_d.v   = mem_q.v;
      wb_d.rd  = mem_q.rd;
      wb_d.wr  = mem_q.wr;
      mem_d.v  = ex_q.v;
      mem_d.rd = ex_q.rd;
      mem_d.wr = ex_q.wr;
      mem_d.ld = ex_q.ld;
      if (ex_bubble) begin
        ex_d = '0;
      end else begin
        ex_d.v   = id_valid;
        ex_d.rs1 = id_rs1;
        ex_d.rs2 = id_rs2;
        ex_d.u1  = id_rs1_used;
        ex_d.u2  = id_rs2_used;
        ex_d.rd  = id_rd;
        ex_d.wr  = id_reg_write;
        ex_d.ld  = id_mem_read;
      end
      if (stall && (stall_cnt_q != CNT_MAX))
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != CNT_MAX))
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench: directed pipeline scenarios plus random traffic
// checked against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK;
  logic          rst;
  logic          hold;
  logic          flush;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          fwd_a_sel0;
  logic          fwd_a_sel1;
  logic          fwd_b_sel0;
  logic          fwd_b_sel1;
  logic          stall;
  logic          ex_bubble;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .CLK(CLK), .rst(rst), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read),
    .fwd_a_sel0(fwd_a_sel0), .fwd_a_sel1(fwd_a_sel1),
    .fwd_b_sel0(fwd_b_sel0), .fwd_b_sel1(fwd_b_sel1),
    .stall(stall), .ex_bubble(ex_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit v;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit wr;
    bit ld;
  } inst_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  inst_t pipe[3];
  int    m_stalls;
  int    m_flushes;
  int    n_checks;
  int    n_err;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // Which older in-flight instruction supplies the operand, youngest first.
  function automatic int m_sel(input bit used, input int rs);
    if (!pipe[0].v || !used) return 0;
    if (pipe[1].v && pipe[1].wr && !pipe[1].ld && pipe[1].rd != 0 && pipe[1].rd == rs)
      return 1;
    if (pipe[2].v && pipe[2].wr && pipe[2].rd != 0 && pipe[2].rd == rs)
      return 2;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit dep;
    if (!(id_valid && pipe[0].v && pipe[0].ld && pipe[0].wr && pipe[0].rd != 0))
      return 0;
    dep = (id_rs1_used && int'(id_rs1) == pipe[0].rd) ||
          (id_rs2_used && int'(id_rs2) == pipe[0].rd);
    return dep && !flush && !hold;
  endfunction

  task automatic model_edge();
    bit s;
    if (rst) begin
      model_reset();
    end else if (!hold) begin
      s = m_stall();
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (s || flush) begin
        pipe[0] = '{default: 0};
      end else begin
        pipe[0].v   = id_valid;
        pipe[0].rs1 = id_rs1;
        pipe[0].rs2 = id_rs2;
        pipe[0].u1  = id_rs1_used;
        pipe[0].u2  = id_rs2_used;
        pipe[0].rd  = id_rd;
        pipe[0].wr  = id_reg_write;
        pipe[0].ld  = id_mem_read;
      end
      if (s && m_stalls < CMAX) m_stalls++;
      if (flush && m_flushes < CMAX) m_flushes++;
    end
  endtask

  task automatic compare_model();
    bit s;
    s = m_stall();
    check("sel_a", {fwd_a_sel1, fwd_a_sel0}, m_sel(pipe[0].u1, pipe[0].rs1));
    check("sel_b", {fwd_b_sel1, fwd_b_sel0}, m_sel(pipe[0].u2, pipe[0].rs2));
    check("stall", stall, s);
    check("ex_bubble", ex_bubble, (s || flush) && !hold);
    check("stall_cnt", stall_cnt, m_stalls);
    check("flush_cnt", flush_cnt, m_flushes);
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2,
                        input bit u1, input bit u2, input int rd,
                        input bit wr, input bit ld);
    id_valid     = v;
    id_rs1       = AW'(rs1);
    id_rs2       = AW'(rs2);
    id_rs1_used  = u1;
    id_rs2_used  = u2;
    id_rd        = AW'(rd);
    id_reg_write = wr;
    id_mem_read  = ld;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) begin
      settle();
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    model_reset();
    rst   = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    set_id(1, 3, 4, 1, 1, 5, 1, 0);
    #1 rst = 1'b1;
    #1;
    check("rst_sel_a", {fwd_a_sel1, fwd_a_sel0}, 0);
    check("rst_sel_b", {fwd_b_sel1, fwd_b_sel0}, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    @(negedge CLK);
    rst = 1'b0;
    nop();

    // back-to-back ALU dependency
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    settle(); tick();
    set_id(1, 5, 5, 1, 1, 6, 1, 0);
    settle();
    check("b2b_stall", stall, 0);
    tick();
    nop();
    settle();
    check("b2b_sel_a", {fwd_a_sel1, fwd_a_sel0}, 1);
    check("b2b_sel_b", {fwd_b_sel1, fwd_b_sel0}, 1);
    drain();

    // distance-2 dependency, then younger override
    set_id(1, 1, 2, 1, 1, 7, 1, 0); settle(); tick();
    set_id(1, 1, 2, 1, 1, 9, 1, 0); settle(); tick();
    set_id(1, 7, 2, 1, 0, 10, 1, 0); settle(); tick();
    nop();
    settle();
    check("dist2_sel_a", {fwd_a_sel1, fwd_a_sel0}, 2);
    drain();
    set_id(1, 1, 2, 1, 1, 7, 1, 0); settle(); tick();
    set_id(1, 2, 3, 1, 1, 7, 1, 0); settle(); tick();
    set_id(1, 7, 2, 1, 0, 10, 1, 0); settle(); tick();
    nop();
    settle();
    check("young_sel_a", {fwd_a_sel1, fwd_a_sel0}, 1);
    drain();

    // load-use: one stall cycle, then forward from WB
    set_id(1, 1, 0, 1, 0, 3, 1, 1); settle(); tick();
    set_id(1, 3, 1, 1, 1, 4, 1, 0);
    settle();
    check("lu_stall", stall, 1);
    check("lu_bubble", ex_bubble, 1);
    tick();
    settle();
    check("lu_stall_once", stall, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    tick();
    nop();
    settle();
    check("lu_sel_a", {fwd_a_sel1, fwd_a_sel0}, 2);
    check("lu_sel_b", {fwd_b_sel1, fwd_b_sel0}, 0);
    drain();

    // flush beats pending stall
    set_id(1, 1, 0, 1, 0, 3, 1, 1); settle(); tick();
    set_id(1, 3, 1, 1, 1, 4, 1, 0);
    flush = 1'b1;
    settle();
    check("fl_stall", stall, 0);
    check("fl_bubble", ex_bubble, 1);
    tick();
    flush = 1'b0;
    nop();
    settle();
    check("fl_flush_cnt", flush_cnt, 1);
    check("fl_stall_cnt", stall_cnt, 1);
    drain();

    // hold freezes a load-use pair, stall resumes after release
    set_id(1, 1, 0, 1, 0, 3, 1, 1); settle(); tick();
    set_id(1, 2, 3, 1, 1, 4, 1, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("hold_stall", stall, 0);
      tick();
    end
    check("hold_stall_cnt", stall_cnt, 1);
    hold = 1'b0;
    settle();
    check("hold_resume_stall", stall, 1);
    tick();
    nop();
    settle();
    check("hold_stall_cnt2", stall_cnt, 2);
    drain();

    // x0 is never a forward source nor a stall cause
    set_id(1, 1, 2, 1, 1, 0, 1, 0); settle(); tick();
    set_id(1, 0, 0, 1, 1, 8, 1, 0);
    settle(); tick();
    nop();
    settle();
    check("x0_sel_a", {fwd_a_sel1, fwd_a_sel0}, 0);
    check("x0_sel_b", {fwd_b_sel1, fwd_b_sel0}, 0);
    set_id(1, 1, 0, 1, 0, 0, 1, 1); settle(); tick();
    set_id(1, 0, 0, 1, 1, 8, 1, 0);
    settle();
    check("x0_ld_stall", stall, 0);
    tick();

    // random traffic with periodic asynchronous resets
    for (int i = 0; i < 2000; i++) begin
      set_id($urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3),
             $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
      hold  = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 5) == 0;
      if (i % 400 == 399) begin
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sel_a", {fwd_a_sel1, fwd_a_sel0}, 0);
        check("mid_rst_sel_b", {fwd_b_sel1, fwd_b_sel0}, 0);
        check("mid_rst_cnt", stall_cnt + flush_cnt, 0);
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        settle();
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Controller that sequences the two 3-input EX-stage operand forwarding muxes of the RV32I 5-stage pipeline.
- Keeps an internal scoreboard of the destination registers in flight in EX, MEM and WB.
- From it, drives {sel1,sel0} for operand A and operand B and detects load-use hazards.
- On a load-use hazard it stalls IF/ID for exactly one cycle and injects a bubble into EX.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 16, width of the saturating stall/flush event counters.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  global freeze (e.g. memory wait); when 1, no scoreboard state changes.
- flush  in  1  taken branch/jump resolved in EX; kills the instruction entering EX.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_AW  ID source register 1.
- id_rs2  in  REG_AW  ID source register 2.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- id_rd  in  REG_AW  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- fwd_a_sel0  out  1  operand-A mux select bit 0.
- fwd_a_sel1  out  1  operand-A mux select bit 1.
- fwd_b_sel0  out  1  operand-B mux select bit 0.
- fwd_b_sel1  out  1  operand-B mux select bit 1.
- stall  out  1  freeze PC and IF/ID this cycle.
- ex_bubble  out  1  EX receives a NOP at the next edge.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of accepted flushes.

Behaviour:
- Scoreboard entries:
  - EX: valid, rs1, rs2, rs1_used, rs2_used, rd, wr, ld.
  - MEM: valid, rd, wr, ld.
  - WB: valid, rd, wr.
- Reset (asynchronous): all valid bits 0 and all fields 0, so every select is 00, stall=0, ex_bubble=0 and both counters are 0 immediately.
- Mux encoding {sel1,sel0}: 00 = register-file value, 01 = EX/MEM result (MEM entry), 10 = MEM/WB result (WB entry). 11 is never driven.
- Operand-A select (combinational from registered state):
  - 01 if MEM.valid & MEM.wr & !MEM.ld & MEM.rd!=0 & EX.rs1_used & MEM.rd==EX.rs1.
  - Otherwise 10 if WB.valid & WB.wr & WB.rd!=0 & EX.rs1_used & WB.rd==EX.rs1.
  - Otherwise 00.
  - Selects are 00 whenever EX.valid=0.
  - MEM has priority over WB, so the youngest producer wins.
- Operand-B select: identical rules using rs2.
- A load in MEM is never a forward source (its data is not ready), but the stall below guarantees this case cannot arise for a dependent instruction.
- Load-use stall: stall = id_valid & EX.valid & EX.ld & EX.wr & EX.rd!=0 & ((id_rs1_used & id_rs1==EX.rd) | (id_rs2_used & id_rs2==EX.rd)). It is combinational with zero-cycle latency.
- Gating: stall is forced to 0 when flush=1 (flush wins) and when hold=1.
- ex_bubble = (stall | flush) & !hold.
- Clock-edge update when hold=0:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble (valid=0, all fields 0) if flush or stall; otherwise EX <= ID fields with valid=id_valid.
- When hold=1: all entries, counters and outputs are frozen; the selects keep reflecting the frozen state.
- Stall duration: exactly 1 cycle per load-use pair, because after the bubble the load sits in MEM and is no longer in EX.
- Counters: stall_cnt increments on each edge where stall=1 & hold=0; flush_cnt increments on each edge where flush=1 & hold=0. Both saturate at 2^CNT_W-1 and never wrap.
- Simultaneous flush and stall: the flush is counted, the stall is not, and a single bubble is inserted.
- Reset mid-operation: every in-flight entry is discarded at once; selects drop to 00 asynchronously.
- Writes to x0 are never forwarded and never cause a stall.

Test Plan:
- Reset: assert rst with arbitrary inputs -> all four selects 0, stall=0, stall_cnt=0, flush_cnt=0 without waiting for a CLK edge.
- Back-to-back ALU dependency: issue add x5 (rd=5, wr=1), then sub x6,x5,x5 (rs1=rs2=5, both used) -> when sub is in EX, A={0,1}=01 and B=01; stall never 1.
- Distance-2 dependency with a younger override:
  - Issue x7 producer, an unrelated instruction, then a consumer of x7 -> A=10.
  - With two x7 producers back-to-back before the consumer -> A=01 (youngest wins).
- Load-use: issue lw x3, then add x4,x3,x1 -> stall=1 and ex_bubble=1 for exactly one cycle, stall_cnt=1; the next cycle add is in EX with A=10 (load now in WB).
- Flush with pending stall: lw x3 in EX, dependent instruction in ID, flush=1 -> stall=0, ex_bubble=1, flush_cnt=1, stall_cnt unchanged.
- Hold and x0: hold=1 for 3 cycles during a load-use pair -> no state or counter change, and the stall resumes after release. A producer with rd=0 followed by a consumer of rs1=0 -> selects 00, no stall.
